conv_stream_loader: RTL and testbench

- Receive side that feeds the conv engine: accepts a raster-ordered valid/ready byte stream carrying one kernel, then one input feature map.
- Writes the stream into parallel weight and ifmap register arrays wired straight to the conv engine's array inputs.
- Holds the conv enable high until the engine reports completion, then emits a frame-done pulse.
- Sits between the external DMA/stream source and the conv engine; one loader per conv instance.

---
 rtl/conv_stream_loader.sv | 156 +++++++++++++++
 tb/tb_conv_stream_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_loader.sv
// Stream receive side for the conv engine: loads one kernel, then one ifmap, from a
// raster-ordered valid/ready byte stream, then runs the engine until it reports done.
module conv_stream_loader #(
  parameter int IFMAP_HEIGHT  = 8,
  parameter int IFMAP_WIDTH   = 8,
  parameter int KERNEL_HEIGHT = 3,
  parameter int KERNEL_WIDTH  = 3,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_last,
  output logic signed [DATA_WIDTH-1:0] weights [0:KERNEL_HEIGHT-1][0:KERNEL_WIDTH-1],
  output logic [DATA_WIDTH-1:0]        ifmap   [0:IFMAP_HEIGHT-1][0:IFMAP_WIDTH-1],
  output logic                         conv_en,
  input  logic                         conv_done,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         err
);

  localparam int KR_W = (KERNEL_HEIGHT > 1) ? $clog2(KERNEL_HEIGHT) : 1;
  localparam int KC_W = (KERNEL_WIDTH  > 1) ? $clog2(KERNEL_WIDTH)  : 1;
  localparam int IR_W = (IFMAP_HEIGHT  > 1) ? $clog2(IFMAP_HEIGHT)  : 1;
  localparam int IC_W = (IFMAP_WIDTH   > 1) ? $clog2(IFMAP_WIDTH)   : 1;

  localparam logic [KR_W-1:0] KR_LAST = KR_W'(KERNEL_HEIGHT - 1);
  localparam logic [KC_W-1:0] KC_LAST = KC_W'(KERNEL_WIDTH - 1);
  localparam logic [IR_W-1:0] IR_LAST = IR_W'(IFMAP_HEIGHT - 1);
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(IFMAP_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, RUN, DONE} state_t;

  state_t          state_reg;
  logic [KR_W-1:0] wr_reg;
  logic [KC_W-1:0] wc_reg;
  logic [IR_W-1:0] ir_reg;
  logic [IC_W-1:0] ic_reg;
  logic            conv_en_reg;
  logic            busy_reg;
  logic            frame_done_reg;
  logic            err_reg;
  logic            run_first_reg;

  logic accept;
  logic w_last_beat;
  logic i_last_beat;

  assign s_ready     = (state_reg == LOAD_W) || (state_reg == LOAD_I);
  assign accept      = s_valid && s_ready;
  assign w_last_beat = (wr_reg == KR_LAST) && (wc_reg == KC_LAST);
  assign i_last_beat = (ir_reg == IR_LAST) && (ic_reg == IC_LAST);

  assign conv_en    = conv_en_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign err        = err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      wr_reg         <= '0;
      wc_reg         <= '0;
      ir_reg         <= '0;
      ic_reg         <= '0;
      conv_en_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
      run_first_reg  <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= LOAD_W;
            wr_reg    <= '0;
            wc_reg    <= '0;
            ir_reg    <= '0;
            ic_reg    <= '0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end
        LOAD_W: begin
          if (accept) begin
            // Only the final ifmap beat may carry s_last.
            if (s_last) err_reg <= 1'b1;
            if (w_last_beat) begin
              wr_reg    <= '0;
              wc_reg    <= '0;
              state_reg <= LOAD_I;
            end else if (wc_reg == KC_LAST) begin
              wc_reg <= '0;
              wr_reg <= wr_reg + 1'b1;
            end else begin
              wc_reg <= wc_reg + 1'b1;
            end
          end
        end
        LOAD_I: begin
          if (accept) begin
            if (s_last != i_last_beat) err_reg <= 1'b1;
            if (i_last_beat) begin
              ir_reg        <= '0;
              ic_reg        <= '0;
              state_reg     <= RUN;
              conv_en_reg   <= 1'b1;
              run_first_reg <= 1'b1;
            end else if (ic_reg == IC_LAST) begin
              ic_reg <= '0;
              ir_reg <= ir_reg + 1'b1;
            end else begin
              ic_reg <= ic_reg + 1'b1;
            end
          end
        end
        RUN: begin
          // A done flag left over from the previous frame is masked on the first RUN cycle.
          run_first_reg <= 1'b0;
          if (!run_first_reg && conv_done) begin
            state_reg      <= DONE;
            conv_en_reg    <= 1'b0;
            frame_done_reg <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < KERNEL_HEIGHT; r++)
        for (int c = 0; c < KERNEL_WIDTH; c++)
          weights[r][c] <= '0;
      for (int r = 0; r < IFMAP_HEIGHT; r++)
        for (int c = 0; c < IFMAP_WIDTH; c++)
          ifmap[r][c] <= '0;
    end else if (accept) begin
      if (state_reg == LOAD_W)
        weights[wr_reg][wc_reg] <= s_data;
      else
        ifmap[ir_reg][ic_reg] <= s_data;
    end
  end

endmodule

// File: tb/tb_conv_stream_loader.sv
// Self-checking bench for conv_stream_loader: table of frame scenarios plus reset and
// stale-done sequences, with a beat scoreboard checked against the loaded arrays.
module tb_conv_stream_loader;

  localparam int IH = 8, IW = 8, KH = 3, KW = 3, DW = 8;
  localparam int NW = KH * KW;
  localparam int NB = NW + IH * IW;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic                 s_valid;
  logic                 s_ready;
  logic [DW-1:0]        s_data;
  logic                 s_last;
  logic signed [DW-1:0] weights [0:KH-1][0:KW-1];
  logic [DW-1:0]        ifmap   [0:IH-1][0:IW-1];
  logic                 conv_en;
  logic                 conv_done;
  logic                 busy;
  logic                 frame_done;
  logic                 err;

  conv_stream_loader #(
    .IFMAP_HEIGHT(IH), .IFMAP_WIDTH(IW), .KERNEL_HEIGHT(KH),
    .KERNEL_WIDTH(KW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .weights(weights), .ifmap(ifmap),
    .conv_en(conv_en), .conv_done(conv_done), .busy(busy),
    .frame_done(frame_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int max_gap;
    int extra_last;
    bit final_last;
    bit noise;
    bit exp_err;
  } vec_t;

  typedef struct {
    bit       is_w;
    int       r;
    int       c;
    logic [7:0] val;
  } beat_t;

  beat_t sb_q[$];
  vec_t  vecs [0:5];
  int    checks = 0;
  int    fails  = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_bit({tag, "_s_ready"}, s_ready, 1'b0);
    check_bit({tag, "_conv_en"}, conv_en, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_frame_done"}, frame_done, 1'b0);
    check_bit({tag, "_err"}, err, 1'b0);
    for (int r = 0; r < KH; r++)
      for (int c = 0; c < KW; c++)
        check_byte($sformatf("%s_weights[%0d][%0d]", tag, r, c), weights[r][c], 8'd0);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        check_byte($sformatf("%s_ifmap[%0d][%0d]", tag, r, c), ifmap[r][c], 8'd0);
  endtask

  task automatic check_scoreboard();
    beat_t b;
    while (sb_q.size() > 0) begin
      b = sb_q.pop_front();
      if (b.is_w)
        check_byte($sformatf("weights[%0d][%0d]", b.r, b.c), weights[b.r][b.c], b.val);
      else
        check_byte($sformatf("ifmap[%0d][%0d]", b.r, b.c), ifmap[b.r][b.c], b.val);
    end
  endtask

  // Presents one beat after an optional gap of idle cycles; returns at the negedge
  // before the accepting posedge.
  task automatic drive_beat(input logic [7:0] d, input bit last, input int gap,
                            input bit ns, input bit nd, output bit ok);
    ok = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
      start = ns; conv_done = nd;
    end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = d; s_last = last; start = ns; conv_done = nd;
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input int base, input int abort_after, input bit hold_done);
    logic [7:0] d;
    bit last, ns, nd, ok;
    int gap;
    @(negedge clk);
    start = 1'b1; s_valid = 1'b0; conv_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_bit("busy_after_start", busy, 1'b1);
    check_bit("err_cleared_by_start", err, 1'b0);
    check_bit("s_ready_in_load", s_ready, 1'b1);
    for (int k = 0; k < NB; k++) begin
      if (k == abort_after) return;
      d    = (k < NW) ? 8'(base + k + 1) : 8'(base * 3 + k - NW);
      last = (k == v.extra_last) || (k == NB - 1 && v.final_last);
      gap  = (v.max_gap > 0) ? int'($urandom_range(0, v.max_gap)) : 0;
      ns   = v.noise && (k >= NW);
      nd   = (v.noise && (k < NW)) || (hold_done && k == NB - 1);
      drive_beat(d, last, gap, ns, nd, ok);
      if (!ok) begin
        checks++; fails++;
        $display("FAIL beat_timeout: beat %0d never accepted, s_ready=%b required 1", k, s_ready);
        s_valid = 1'b0;
        return;
      end
      if (k < NW) sb_q.push_back('{1'b1, k / KW, k % KW, d});
      else        sb_q.push_back('{1'b0, (k - NW) / IW, (k - NW) % IW, d});
      if (v.extra_last >= 0 && k == v.extra_last)     check_bit("err_before_bad_last", err, 1'b0);
      if (v.extra_last >= 0 && k == v.extra_last + 1) check_bit("err_after_bad_last", err, 1'b1);
      if (k == NB - 1) check_bit("conv_en_before_final_beat", conv_en, 1'b0);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; start = v.noise; conv_done = hold_done;
    check_bit("conv_en_after_final_beat", conv_en, 1'b1);
    check_bit("s_ready_in_run", s_ready, 1'b0);
    check_bit("busy_in_run", busy, 1'b1);
    check_bit("err_at_run", err, v.exp_err);
    check_bit("frame_done_in_run", frame_done, 1'b0);
    check_scoreboard();
    if (hold_done) begin
      @(negedge clk);
      check_bit("stale_done_ignored_conv_en", conv_en, 1'b1);
      check_bit("stale_done_ignored_frame_done", frame_done, 1'b0);
    end else begin
      repeat (4) @(negedge clk);
      check_bit("conv_en_held", conv_en, 1'b1);
      conv_done = 1'b1;
    end
    @(negedge clk);
    conv_done = 1'b0;
    check_bit("frame_done_pulse", frame_done, 1'b1);
    check_bit("conv_en_dropped", conv_en, 1'b0);
    check_bit("busy_in_done", busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check_bit("frame_done_single", frame_done, 1'b0);
    check_bit("busy_back_idle", busy, 1'b0);
    check_bit("err_sticky", err, v.exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {max_gap, extra_last beat index, s_last on final beat, ignored-input noise, err expected}
    vecs[0] = '{0, -1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{3, -1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{0,  3, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{2, -1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1, 40, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1, -1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; conv_done = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], i * 17, -1, 1'b0);
      if (i == 0) begin
        check_byte("nominal_weights[2][2]", weights[2][2], 8'd9);
        check_byte("nominal_ifmap[7][7]", ifmap[7][7], 8'd63);
        check_byte("nominal_ifmap[1][0]", ifmap[1][0], 8'd8);
      end
      $display("frame %0d done: gap=%0d extra_last=%0d final_last=%0b noise=%0b err=%0b",
               i, vecs[i].max_gap, vecs[i].extra_last, vecs[i].final_last, vecs[i].noise, err);
    end

    run_frame(vecs[0], 99, -1, 1'b1);
    $display("stale conv_done frame done");

    run_frame(vecs[1], 50, 40, 1'b0);
    @(posedge clk);
    #2;
    s_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_idle_zero("midreset");
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    $display("mid-load reset applied after 40 beats");

    run_frame(vecs[0], 0, -1, 1'b0);
    check_byte("fresh_weights[0][0]", weights[0][0], 8'd1);
    check_byte("fresh_ifmap[7][7]", ifmap[7][7], 8'd63);
    $display("fresh frame after reset done");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
